fact_bus_slave: RTL and testbench

Bus-side responder that owns the factorial core's control interface. It turns host register writes into single-cycle op_start/op_clear pulses and an operand value. It tracks core progress, captures the result on core_done, and drives status and interrupt back to the host. It sits between the system bus and the factorial datapath and next-state logic.

---
 rtl/fact_bus_slave.sv | 143 ++++++++++++++
 tb/tb_fact_bus_slave.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fact_bus_slave.sv
// Host register front-end for the factorial core; optional sticky error flag under FACT_SLAVE_ERR_EN.
// Latency: reads return on S_dout one cycle after the request; op_start/op_clear pulse the cycle after the write.
// Backpressure: none, the bus accepts one transfer every cycle; disallowed writes are dropped.
module fact_bus_slave #(
  parameter int ADDR_W   = 8,
  parameter int RESULT_W = 128
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                S_sel,
  input  logic                S_wr,
  input  logic [ADDR_W-1:0]   S_addr,
  input  logic [63:0]         S_din,
  output logic [63:0]         S_dout,
  output logic                interrupt,
  output logic                op_start,
  output logic                op_clear,
  output logic [63:0]         operand,
  input  logic                core_done,
  input  logic [RESULT_W-1:0] result
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [63:0]         s_dout_q, s_dout_d;
  logic [63:0]         operand_q, operand_d;
  logic [RESULT_W-1:0] result_q, result_d;
  logic                intr_en_q, intr_en_d;
  logic                op_start_q, op_start_d;
  logic                op_clear_q, op_clear_d;
  logic                interrupt_q, interrupt_d;
  logic                err_flag;

  logic       wr_en, rd_en, mapped, clear_req, start_req, capture;
  logic [2:0] idx;
  logic [63:0] status;

  assign wr_en  = S_sel & S_wr;
  assign rd_en  = S_sel & ~S_wr;
  assign idx    = S_addr[5:3];
  assign mapped = (S_addr[2:0] == 3'd0) && (S_addr[ADDR_W-1:6] == '0);

  assign clear_req = wr_en & mapped & (idx == 3'd1) & S_din[0];
  assign start_req = wr_en & mapped & (idx == 3'd0) & S_din[0] & (state_q == ST_IDLE);
  // An abort in the same cycle as core_done wins: the late result is discarded.
  assign capture   = (state_q == ST_BUSY) & core_done & ~clear_req;

`ifdef FACT_SLAVE_ERR_EN
  logic err_q, err_d;
  logic busy_rej, bad_addr;

  assign busy_rej = wr_en & mapped & (state_q == ST_BUSY) &
                    (((idx == 3'd0) & S_din[0]) | (idx == 3'd4));
  assign bad_addr = wr_en & (~mapped | (idx == 3'd7));

  always_comb begin
    err_d = err_q | busy_rej | bad_addr;
    if (clear_req) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign err_flag = err_q;
`else
  assign err_flag = 1'b0;
`endif

  assign status = {61'd0, err_flag, state_q == ST_BUSY, state_q == ST_DONE};

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    operand_d   = operand_q;
    intr_en_d   = intr_en_q;
    s_dout_d    = s_dout_q;
    op_start_d  = start_req;
    op_clear_d  = clear_req;
    interrupt_d = intr_en_q & ((state_q == ST_DONE) | err_flag);

    if (clear_req) begin
      state_d  = ST_IDLE;
      result_d = '0;
    end else if (start_req) begin
      state_d = ST_BUSY;
    end else if (capture) begin
      state_d  = ST_DONE;
      result_d = result;
    end

    if (wr_en && mapped && idx == 3'd3) intr_en_d = S_din[0];
    if (wr_en && mapped && idx == 3'd4 && state_q != ST_BUSY) operand_d = S_din;

    // Reads see the registers as they stood before this edge.
    if (rd_en) begin
      s_dout_d = 64'd0;
      if (mapped) begin
        case (idx)
          3'd2:    s_dout_d = status;
          3'd3:    s_dout_d = {63'd0, intr_en_q};
          3'd4:    s_dout_d = operand_q;
          3'd5:    s_dout_d = result_q[RESULT_W-1:64];
          3'd6:    s_dout_d = result_q[63:0];
          default: s_dout_d = 64'd0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      operand_q   <= 64'd0;
      intr_en_q   <= 1'b0;
      s_dout_q    <= 64'd0;
      op_start_q  <= 1'b0;
      op_clear_q  <= 1'b0;
      interrupt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      operand_q   <= operand_d;
      intr_en_q   <= intr_en_d;
      s_dout_q    <= s_dout_d;
      op_start_q  <= op_start_d;
      op_clear_q  <= op_clear_d;
      interrupt_q <= interrupt_d;
    end
  end

  assign S_dout    = s_dout_q;
  assign operand   = operand_q;
  assign op_start  = op_start_q;
  assign op_clear  = op_clear_q;
  assign interrupt = interrupt_q;

endmodule

// File: tb/tb_fact_bus_slave.sv
// Bench for fact_bus_slave: register table, directed operation sequences, then random traffic vs a model.
module tb_fact_bus_slave;

`ifdef FACT_SLAVE_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic         clk, reset_n;
  logic         S_sel, S_wr;
  logic [7:0]   S_addr;
  logic [63:0]  S_din, S_dout, operand;
  logic         interrupt, op_start, op_clear, core_done;
  logic [127:0] result;

  int checks = 0;
  int errors = 0;

  fact_bus_slave #(.ADDR_W(8), .RESULT_W(128)) dut (
    .clk(clk), .reset_n(reset_n), .S_sel(S_sel), .S_wr(S_wr), .S_addr(S_addr),
    .S_din(S_din), .S_dout(S_dout), .interrupt(interrupt), .op_start(op_start),
    .op_clear(op_clear), .operand(operand), .core_done(core_done), .result(result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [63:0] wdata;
    logic [63:0] exp;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Both bus tasks start and end on a falling edge.
  task automatic bus_wr(input logic [7:0] a, input logic [63:0] d);
    S_sel = 1'b1; S_wr = 1'b1; S_addr = a; S_din = d;
    @(posedge clk);
    @(negedge clk);
    S_sel = 1'b0; S_wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [63:0] d);
    S_sel = 1'b1; S_wr = 1'b0; S_addr = a;
    @(posedge clk);
    @(negedge clk);
    S_sel = 1'b0;
    d = S_dout;
  endtask

  task automatic pulse_done(input logic [127:0] r);
    core_done = 1'b1; result = r;
    @(posedge clk);
    @(negedge clk);
    core_done = 1'b0;
  endtask

  // Reference model state
  int           m_ph;   // 0 idle, 1 busy, 2 done
  logic [63:0]  m_operand, m_dout;
  logic [127:0] m_res;
  logic         m_intr_en, m_err, m_int, m_start, m_clear;

  logic [63:0]  rd;
  logic         r_sel, r_wr, r_done, r_mapped;
  logic [7:0]   r_addr;
  logic [63:0]  r_din;
  logic [127:0] r_res;
  logic [2:0]   r_idx;
  int           b;

  initial begin
    reset_n = 1'b0; S_sel = 1'b0; S_wr = 1'b0; S_addr = 8'd0; S_din = 64'd0;
    core_done = 1'b0; result = 128'd0;
    repeat (2) @(negedge clk);
    chk("rst_dout", S_dout, 64'd0);
    chk("rst_int", {63'd0, interrupt}, 64'd0);
    chk("rst_start", {63'd0, op_start}, 64'd0);
    chk("rst_clear", {63'd0, op_clear}, 64'd0);
    chk("rst_operand", operand, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) vt.push_back('{1'b0, 8'(i * 8), 64'd0, 64'd0});
    vt.push_back('{1'b1, 8'h18, 64'd3, 64'd0});
    vt.push_back('{1'b0, 8'h18, 64'd0, 64'd1});
    vt.push_back('{1'b1, 8'h20, 64'hDEAD_BEEF_0123_4567, 64'd0});
    vt.push_back('{1'b0, 8'h20, 64'd0, 64'hDEAD_BEEF_0123_4567});
    vt.push_back('{1'b0, 8'h21, 64'd0, 64'd0});
    vt.push_back('{1'b0, 8'h60, 64'd0, 64'd0});
    vt.push_back('{1'b1, 8'h61, 64'h55, 64'd0});
    vt.push_back('{1'b0, 8'h20, 64'd0, 64'hDEAD_BEEF_0123_4567});
    vt.push_back('{1'b1, 8'h38, 64'hFF, 64'd0});
    vt.push_back('{1'b0, 8'h38, 64'd0, 64'd0});
    vt.push_back('{1'b0, 8'h10, 64'd0, ERR_ON ? 64'd4 : 64'd0});
    vt.push_back('{1'b1, 8'h08, 64'd1, 64'd0});
    vt.push_back('{1'b0, 8'h10, 64'd0, 64'd0});
    vt.push_back('{1'b1, 8'h18, 64'd0, 64'd0});
    vt.push_back('{1'b0, 8'h18, 64'd0, 64'd0});
    foreach (vt[i]) begin
      if (vt[i].wr) bus_wr(vt[i].addr, vt[i].wdata);
      else begin
        bus_rd(vt[i].addr, rd);
        chk($sformatf("tbl%0d_rd%02h", i, vt[i].addr), rd, vt[i].exp);
      end
    end

    // Normal operation with interrupt enabled
    bus_wr(8'h18, 64'd1);
    bus_wr(8'h20, 64'd5);
    bus_wr(8'h00, 64'd1);
    chk("start_pulse", {63'd0, op_start}, 64'd1);
    chk("start_operand", operand, 64'd5);
    @(negedge clk);
    chk("start_pulse_end", {63'd0, op_start}, 64'd0);
    bus_rd(8'h10, rd); chk("status_busy", rd, 64'd2);
    pulse_done(128'h78);
    chk("int_cap_edge", {63'd0, interrupt}, 64'd0);
    @(negedge clk);
    chk("int_after_cap", {63'd0, interrupt}, 64'd1);
    bus_rd(8'h10, rd); chk("status_done", rd, 64'd1);
    bus_rd(8'h30, rd); chk("result_l", rd, 64'h78);
    bus_rd(8'h28, rd); chk("result_h", rd, 64'd0);
    bus_wr(8'h08, 64'd1);
    chk("clear_pulse", {63'd0, op_clear}, 64'd1);
    @(negedge clk);
    chk("clear_pulse_end", {63'd0, op_clear}, 64'd0);
    chk("int_after_clear", {63'd0, interrupt}, 64'd0);

    // Writes rejected while busy
    bus_wr(8'h00, 64'd1);
    bus_wr(8'h20, 64'd9);
    bus_wr(8'h00, 64'd1);
    chk("busy_no_start", {63'd0, op_start}, 64'd0);
    chk("busy_operand", operand, 64'd5);
    bus_rd(8'h10, rd); chk("busy_status", rd, ERR_ON ? 64'd6 : 64'd2);

    // Abort while busy, late core_done ignored
    bus_wr(8'h08, 64'd1);
    chk("abort_clear", {63'd0, op_clear}, 64'd1);
    @(negedge clk);
    chk("abort_clear_end", {63'd0, op_clear}, 64'd0);
    pulse_done(128'h78);
    bus_rd(8'h10, rd); chk("abort_status", rd, 64'd0);
    bus_rd(8'h30, rd); chk("abort_result_l", rd, 64'd0);
    chk("abort_int", {63'd0, interrupt}, 64'd0);

    // Asynchronous reset mid-busy
    bus_wr(8'h20, 64'd7);
    bus_wr(8'h00, 64'd1);
    bus_rd(8'h10, rd); chk("pre_rst_status", rd, 64'd2);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_dout", S_dout, 64'd0);
    chk("arst_operand", operand, 64'd0);
    chk("arst_start", {63'd0, op_start}, 64'd0);
    chk("arst_clear", {63'd0, op_clear}, 64'd0);
    chk("arst_int", {63'd0, interrupt}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("arst_no_clear", {63'd0, op_clear}, 64'd0);
    bus_rd(8'h10, rd); chk("post_rst_status", rd, 64'd0);
    bus_rd(8'h18, rd); chk("post_rst_intr_en", rd, 64'd0);
    bus_wr(8'h20, 64'd3);
    bus_wr(8'h00, 64'd1);
    chk("post_rst_start", {63'd0, op_start}, 64'd1);
    chk("post_rst_operand", operand, 64'd3);
    bus_rd(8'h10, rd); chk("post_rst_busy", rd, 64'd2);

    // Random traffic against the model, from a fresh reset
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    m_ph = 0; m_operand = 64'd0; m_dout = 64'd0; m_res = 128'd0;
    m_intr_en = 1'b0; m_err = 1'b0; m_int = 1'b0; m_start = 1'b0; m_clear = 1'b0;
    for (int c = 0; c < 400; c++) begin
      chk("rnd_dout", S_dout, m_dout);
      chk("rnd_int", {63'd0, interrupt}, {63'd0, m_int});
      chk("rnd_start", {63'd0, op_start}, {63'd0, m_start});
      chk("rnd_clear", {63'd0, op_clear}, {63'd0, m_clear});
      chk("rnd_operand", operand, m_operand);

      b = $urandom_range(0, 9);
      r_sel = (b < 6); r_wr = (b < 3);
      r_idx = 3'($urandom_range(0, 7));
      if (r_idx == 3'd1 && $urandom_range(0, 3) != 0) r_idx = 3'd0;
      r_addr = {2'b00, r_idx, 3'b000};
      if ($urandom_range(0, 9) == 0) begin
        b = $urandom_range(0, 4);
        r_addr = r_addr | (8'd1 << ((b < 3) ? b : b + 3));
      end
      r_din = {$urandom, $urandom};
      r_din[0] = ($urandom_range(0, 3) != 0);
      r_done = ($urandom_range(0, 3) == 0);
      r_res = {$urandom, $urandom, $urandom, $urandom};
      S_sel = r_sel; S_wr = r_wr; S_addr = r_addr; S_din = r_din;
      core_done = r_done; result = r_res;

      r_mapped = (r_addr[2:0] == 3'd0) && (r_addr[7:6] == 2'd0);
      r_idx = r_addr[5:3];
      m_int = m_intr_en & ((m_ph == 2) | (ERR_ON & m_err));
      if (r_sel && !r_wr) begin
        m_dout = 64'd0;
        if (r_mapped) begin
          if (r_idx == 3'd2) m_dout = {61'd0, ERR_ON & m_err, m_ph == 1, m_ph == 2};
          if (r_idx == 3'd3) m_dout = {63'd0, m_intr_en};
          if (r_idx == 3'd4) m_dout = m_operand;
          if (r_idx == 3'd5) m_dout = m_res[127:64];
          if (r_idx == 3'd6) m_dout = m_res[63:0];
        end
      end
      m_start = r_sel && r_wr && r_mapped && r_idx == 3'd0 && r_din[0] && m_ph == 0;
      m_clear = r_sel && r_wr && r_mapped && r_idx == 3'd1 && r_din[0];
      if (r_sel && r_wr) begin
        if (!r_mapped || r_idx == 3'd7) m_err = 1'b1;
        if (r_mapped && m_ph == 1 && (r_idx == 3'd4 || (r_idx == 3'd0 && r_din[0]))) m_err = 1'b1;
        if (r_mapped && r_idx == 3'd3) m_intr_en = r_din[0];
        if (r_mapped && r_idx == 3'd4 && m_ph != 1) m_operand = r_din;
      end
      if (m_clear) begin
        m_ph = 0; m_res = 128'd0; m_err = 1'b0;
      end else if (m_start) begin
        m_ph = 1;
      end else if (m_ph == 1 && r_done) begin
        m_ph = 2; m_res = r_res;
      end
      @(negedge clk);
    end
    S_sel = 1'b0; core_done = 1'b0;
    chk("rnd_last_dout", S_dout, m_dout);
    chk("rnd_last_int", {63'd0, interrupt}, {63'd0, m_int});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
